// File: rtl/multi_line_fb.sv
// Ring of NUM_BUFS line buffers in one single-clock RAM. The writer fills one line
// while the reader drains completed lines. Read latency is one cycle.
module multi_line_fb #(
    parameter int DISPLAY_WIDTH = 640,
    parameter int NUM_BUFS      = 2,
    parameter int COLORS        = 3,
    parameter int COLOR_DEPTH   = 8,
    parameter int DATA_WIDTH    = COLORS * COLOR_DEPTH,
    parameter int AW            = $clog2(DISPLAY_WIDTH),
    parameter int BW            = $clog2(NUM_BUFS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_done,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    input  logic                  rd_done,
    output logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [BW-1:0]         wr_buf_idx,
    output logic [BW-1:0]         rd_buf_idx,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int              DEPTH    = NUM_BUFS * DISPLAY_WIDTH;
    localparam int              PAW      = $clog2(DEPTH);
    localparam logic [AW:0]     LINE_LIM = (AW+1)'(DISPLAY_WIDTH);
    localparam logic [BW:0]     CNT_MAX  = (BW+1)'(NUM_BUFS);
    localparam logic [BW-1:0]   PTR_LAST = BW'(NUM_BUFS - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [BW-1:0]         wr_ptr;
    logic [BW-1:0]         rd_ptr;
    logic [BW:0]           cnt;
    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic                  vld_p1;
    logic                  wr_hit;
    logic                  rd_hit;
    logic                  wr_acc;
    logic                  rd_acc;

    function automatic logic [PAW-1:0] phys_addr(input logic [BW-1:0] b, input logic [AW-1:0] a);
        return PAW'(int'(b) * DISPLAY_WIDTH + int'(a));
    endfunction

    function automatic logic [BW-1:0] ptr_next(input logic [BW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign wr_ready   = (cnt < CNT_MAX);
    assign rd_ready   = (cnt != '0);
    assign wr_buf_idx = wr_ptr;
    assign rd_buf_idx = rd_ptr;

    assign wr_hit = !rst && wr_en && wr_ready && ({1'b0, wr_addr} < LINE_LIM);
    assign rd_hit = rd_ready && ({1'b0, rd_addr} < LINE_LIM);
    assign wr_acc = wr_done && wr_ready;
    assign rd_acc = rd_done && rd_ready;

    // Writes use the pre-advance wr_ptr, so a pixel sent with wr_done lands in the finishing line.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem[phys_addr(wr_ptr, wr_addr)] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (wr_done && !wr_ready) overflow <= 1'b1;
            if ((rd_done || rd_en) && !rd_ready) underflow <= 1'b1;
        end
    end

    // Stage p1: registered read; misses return zero, data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en) begin
                rd_data_p1 <= rd_hit ? mem[phys_addr(rd_ptr, rd_addr)] : '0;
            end
        end
    end

    assign rd_valid = vld_p1;
    assign rd_data  = rd_data_p1;

endmodule

// File: doc/multi_line_fb.md
MULTI_LINE_FB -- requirements
Module: multi_line_fb

Interface
REQ-001 The block SHALL have parameter DISPLAY_WIDTH, default 640, meaning pixels per line buffer.
REQ-002 The block SHALL have parameter NUM_BUFS, default 2, meaning line buffers in rotation (legal range 2..8).
REQ-003 The block SHALL have parameter COLORS, default 3, meaning channels per pixel.
REQ-004 The block SHALL have parameter COLOR_DEPTH, default 8, meaning bits per channel.
REQ-005 The block SHALL have derived parameters DATA_WIDTH = COLORS*COLOR_DEPTH, AW = $clog2(DISPLAY_WIDTH) and BW = $clog2(NUM_BUFS).
REQ-006 The block SHALL have port clk, input, 1 bit, the clock.
REQ-007 The block SHALL have port rst, input, 1 bit, reset (synchronous, active-high).
REQ-008 The block SHALL have port wr_en, input, 1, pixel write strobe.
REQ-009 The block SHALL have port wr_addr, input, AW, pixel index within the line.
REQ-010 The block SHALL have port wr_data, input, DATA_WIDTH, pixel value.
REQ-011 The block SHALL have port wr_done, input, 1, writer finished the current line (pulse).
REQ-012 The block SHALL have port wr_ready, output, 1, a free buffer is owned by the writer.
REQ-013 The block SHALL have port rd_en, input, 1, pixel read request.
REQ-014 The block SHALL have port rd_addr, input, AW, pixel index within the line.
REQ-015 The block SHALL have port rd_done, input, 1, reader released the current line (pulse).
REQ-016 The block SHALL have port rd_ready, output, 1, at least one completed line is available.
REQ-017 The block SHALL have port rd_data, output, DATA_WIDTH, read pixel.
REQ-018 The block SHALL have port rd_valid, output, 1, rd_data is valid.
REQ-019 The block SHALL have ports wr_buf_idx and rd_buf_idx, outputs, BW each, current writer and reader buffer indices.
REQ-020 The block SHALL have ports overflow and underflow, outputs, 1 each, sticky error flags.

Function
REQ-021 Storage SHALL be a single inferred single-clock RAM of NUM_BUFS*DISPLAY_WIDTH words; physical address = buf_idx*DISPLAY_WIDTH + addr.
REQ-022 Buffers SHALL rotate as a ring: wr_ptr and rd_ptr (each 0..NUM_BUFS-1, wrapping at NUM_BUFS to 0) and full count cnt (0..NUM_BUFS).
REQ-023 The block SHALL drive wr_ready = (cnt < NUM_BUFS), rd_ready = (cnt > 0), wr_buf_idx = wr_ptr and rd_buf_idx = rd_ptr.
REQ-024 A write with wr_en=1, wr_ready=1 and wr_addr < DISPLAY_WIDTH SHALL update buffer wr_ptr at the next edge; any other write SHALL be dropped without error.
REQ-025 wr_done with wr_ready=1 SHALL advance wr_ptr (with wrap) and increment cnt; wr_done with wr_ready=0 SHALL be ignored and set overflow.
REQ-026 rd_done with rd_ready=1 SHALL advance rd_ptr (with wrap) and decrement cnt; rd_done with rd_ready=0 SHALL be ignored and set underflow.
REQ-027 When wr_done and rd_done are accepted in the same cycle, both pointers SHALL advance and cnt SHALL be unchanged.
REQ-028 A write in the same cycle as wr_done SHALL land in the pre-advance buffer.
REQ-029 A read with rd_en=1 SHALL produce rd_valid=1 exactly one cycle later (latency 1, fully pipelined, one result per cycle).
REQ-030 Read data SHALL come from buffer rd_ptr as sampled in the request cycle, including when rd_done occurs in the same cycle.
REQ-031 A read with rd_ready=0 or rd_addr >= DISPLAY_WIDTH SHALL still return rd_valid=1 with rd_data=0 and SHALL set underflow (when rd_ready=0 only).
REQ-032 rd_data SHALL hold its last value while rd_valid=0.
REQ-033 Same-address read/write SHALL be impossible by construction (writer and reader never share a buffer while cnt bounds hold); no bypass SHALL be built.
REQ-034 overflow and underflow SHALL clear only on rst.

Reset
REQ-035 rst SHALL set wr_ptr=0, rd_ptr=0, cnt=0, rd_valid=0, rd_data=0, overflow=0 and underflow=0, giving wr_ready=1 and rd_ready=0 in the cycle after.
REQ-036 rst SHALL take priority over all inputs in the same cycle, and a read in flight at reset SHALL produce no rd_valid.
REQ-037 RAM contents SHALL NOT be cleared by rst.

Verification
REQ-038 Fill line 0 (data = addr), wr_done, then read addr 0..639 -> rd_ready=1, rd_valid one cycle after each rd_en, rd_data = addr, wr_buf_idx=1.
REQ-039 With NUM_BUFS=2, issue two wr_done without rd_done -> wr_ready=0, and a third wr_done -> overflow=1 with wr_buf_idx still 0.
REQ-040 rd_done with cnt=0 -> underflow=1, rd_ptr=0; rd_en with cnt=0 -> rd_valid=1, rd_data=0.
REQ-041 With cnt=1, assert wr_done and rd_done in the same cycle -> cnt stays 1, both indices advance, and a rd_en in that cycle returns the old buffer data.
REQ-042 With NUM_BUFS=3, cycle 7 lines through the buffers -> indices wrap 2->0 and the data of each line matches its written pattern (line n, pixel p = n*1000+p).
REQ-043 Assert rst mid-line with a read pending -> next cycle rd_valid=0, wr_ready=1, rd_ready=0, flags clear; wr_addr=640 write -> no RAM change.
